// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // funct3 values the ALU decoder implements for R/I arithmetic ops
  function automatic logic funct3_legal(input logic [2:0] funct3);
    return (funct3 == 3'b000) || (funct3 == 3'b010) ||
           (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/mc_controller_alu_dec.sv
// Combinational ALU decoder: maps ALUOp plus instruction funct fields to
// the ALU operation code.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op[5]=1) can select sub; addi ignores funct7
          3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, driving datapath enables and mux selects.
module mc_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  state_t     state, next_state;
  logic       pc_update;
  logic       branch;
  logic       illegal_dec;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = S_FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    illegal_dec = 1'b0;
    alu_op      = ALUOP_ADD;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;

    case (state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
        pc_update  = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R: begin
            if (funct3_legal(funct3)) next_state = S_EXECUTER;
            else                      illegal_dec = 1'b1;
          end
          OP_I: begin
            if (funct3_legal(funct3)) next_state = S_EXECUTEI;
            else                      illegal_dec = 1'b1;
          end
          OP_BEQ:  next_state = S_BEQ;
          OP_JAL:  next_state = S_JAL;
          default: illegal_dec = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase

    // reset masks every side effect in the same cycle, not just the next one
    PCWrite = (pc_update | (branch & zero)) & ~reset;
    illegal = illegal_dec & ~reset;
    if (reset) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction cycle tables from an
// instruction-level model feed a queue that a negedge monitor drains.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [2:0] aluc;
    logic       ill;
  } outv_t;

  typedef struct {
    outv_t val;
    outv_t mask;
    int    kind;
    int    idx;
    int    cyc;
  } exp_t;

  localparam int K_LW = 0, K_SW = 1, K_ADD = 2, K_SUB = 3, K_SLT = 4, K_OR = 5,
                 K_AND = 6, K_ADDI = 7, K_SLTI = 8, K_ORI = 9, K_ANDI = 10,
                 K_BEQ = 11, K_JAL = 12, K_BADOP = 13, K_BADF3R = 14,
                 K_BADF3I = 15, K_RESET = 16, NKIND = 16;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   instr_idx  = 0;

  function automatic string kind_name(input int k);
    case (k)
      K_LW: return "lw";       K_SW: return "sw";      K_ADD: return "add";
      K_SUB: return "sub";     K_SLT: return "slt";    K_OR: return "or";
      K_AND: return "and";     K_ADDI: return "addi";  K_SLTI: return "slti";
      K_ORI: return "ori";     K_ANDI: return "andi";  K_BEQ: return "beq";
      K_JAL: return "jal";     K_BADOP: return "bad_op";
      K_BADF3R: return "bad_f3_r"; K_BADF3I: return "bad_f3_i";
      default: return "reset";
    endcase
  endfunction

  function automatic bit is_r(input int k);
    return k inside {K_ADD, K_SUB, K_SLT, K_OR, K_AND};
  endfunction

  function automatic bit is_i(input int k);
    return k inside {K_ADDI, K_SLTI, K_ORI, K_ANDI};
  endfunction

  function automatic int n_cycles(input int k);
    if (k == K_LW) return 5;
    if (k == K_BEQ) return 3;
    if (k inside {K_BADOP, K_BADF3R, K_BADF3I}) return 2;
    return 4;
  endfunction

  function automatic logic [2:0] arith_code(input int k);
    case (k)
      K_SUB:         return 3'b001;
      K_SLT, K_SLTI: return 3'b101;
      K_OR, K_ORI:   return 3'b011;
      K_AND, K_ANDI: return 3'b010;
      default:       return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input int k);
    case (k)
      K_SW:    return 2'b01;
      K_BEQ:   return 2'b10;
      K_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Expected outputs for cycle c (0 = fetch) of an instruction of kind k.
  function automatic outv_t expect_cycle(input int k, input int c, input logic z,
                                         input logic [1:0] imm);
    outv_t v = '0;
    v.imm = imm;
    if (c == 0) begin
      v.pcw = 1'b1; v.irw = 1'b1; v.res = 2'b10; v.srcb = 2'b10;
    end else if (c == 1) begin
      v.srca = 2'b01; v.srcb = 2'b01;
      v.ill  = k inside {K_BADOP, K_BADF3R, K_BADF3I};
    end else if (k == K_LW || k == K_SW) begin
      if (c == 2) begin v.srca = 2'b10; v.srcb = 2'b01; end
      else if (k == K_SW) begin v.adr = 1'b1; v.memw = 1'b1; end
      else if (c == 3) v.adr = 1'b1;
      else begin v.res = 2'b01; v.regw = 1'b1; end
    end else if (is_r(k) || is_i(k)) begin
      if (c == 2) begin
        v.srca = 2'b10; v.srcb = is_i(k) ? 2'b01 : 2'b00; v.aluc = arith_code(k);
      end else v.regw = 1'b1;
    end else if (k == K_BEQ) begin
      v.srca = 2'b10; v.aluc = 3'b001; v.pcw = z;
    end else if (k == K_JAL) begin
      if (c == 2) begin v.srca = 2'b01; v.srcb = 2'b10; v.pcw = 1'b1; end
      else v.regw = 1'b1;
    end
    return v;
  endfunction

  function automatic outv_t full_mask();
    outv_t m = '1;
    return m;
  endfunction

  function automatic outv_t reset_mask();
    outv_t m = '0;
    m.pcw = 1'b1; m.memw = 1'b1; m.irw = 1'b1; m.regw = 1'b1; m.ill = 1'b1;
    return m;
  endfunction

  task automatic push_reset_cycle(input int c);
    exp_t e;
    e.val = '0; e.mask = reset_mask(); e.kind = K_RESET; e.idx = instr_idx; e.cyc = c;
    sb.push_back(e);
  endtask

  // zfix/f7fix: -1 selects a random value each time
  task automatic run_instr(input int k, input int abort_at, input int zfix, input int f7fix);
    logic [2:0] bad3 [4] = '{3'b001, 3'b011, 3'b100, 3'b101};
    logic [6:0] badop [4] = '{7'b1111111, 7'b0010111, 7'b0110111, 7'b0000000};
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    exp_t       e;
    f3 = 3'($urandom);
    f7 = (f7fix < 0) ? 1'($urandom) : 1'(f7fix);
    case (k)
      K_LW:  begin o = 7'b0000011; f3 = 3'b010; end
      K_SW:  begin o = 7'b0100011; f3 = 3'b010; end
      K_ADD: begin o = 7'b0110011; f3 = 3'b000; f7 = 1'b0; end
      K_SUB: begin o = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
      K_SLT: begin o = 7'b0110011; f3 = 3'b010; end
      K_OR:  begin o = 7'b0110011; f3 = 3'b110; end
      K_AND: begin o = 7'b0110011; f3 = 3'b111; end
      K_ADDI: begin o = 7'b0010011; f3 = 3'b000; end
      K_SLTI: begin o = 7'b0010011; f3 = 3'b010; end
      K_ORI:  begin o = 7'b0010011; f3 = 3'b110; end
      K_ANDI: begin o = 7'b0010011; f3 = 3'b111; end
      K_BEQ:  begin o = 7'b1100011; f3 = 3'b000; end
      K_JAL:  o = 7'b1101111;
      K_BADF3R: begin o = 7'b0110011; f3 = bad3[$urandom_range(3)]; end
      K_BADF3I: begin o = 7'b0010011; f3 = bad3[$urandom_range(3)]; end
      default: o = badop[$urandom_range(3)];
    endcase
    for (int c = 0; c < n_cycles(k); c++) begin
      @(posedge clk);
      #1;
      reset    = 1'b0;
      op       = o;
      funct3   = f3;
      funct7_5 = f7;
      zero     = (zfix < 0) ? 1'($urandom) : 1'(zfix);
      if (c == abort_at) begin
        reset = 1'b1;
        push_reset_cycle(c);
        break;
      end
      e.val  = expect_cycle(k, c, zero, imm_of(k));
      e.mask = full_mask();
      e.kind = k; e.idx = instr_idx; e.cyc = c;
      sb.push_back(e);
    end
    instr_idx++;
  endtask

  initial begin : monitor
    exp_t  e;
    outv_t a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
              ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};
        compared++;
        if (((a ^ e.val) & e.mask) != '0) begin
          mismatched++;
          $display("FAIL %s#%0d cycle %0d: got %b want %b (mask %b) [pcw adr memw irw regw res srca srcb imm aluc ill]",
                   kind_name(e.kind), e.idx, e.cyc + 1, a, e.val, e.mask);
        end
      end
    end
  end

  initial begin : driver
    int k;
    reset = 1'b1; op = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      push_reset_cycle(c);
    end
    run_instr(K_LW,   -1, -1, -1);
    run_instr(K_SW,   -1, -1, -1);
    run_instr(K_SUB,  -1, -1, -1);
    run_instr(K_ADDI, -1, -1,  1);
    run_instr(K_OR,   -1, -1, -1);
    run_instr(K_AND,  -1, -1, -1);
    run_instr(K_SLT,  -1, -1, -1);
    run_instr(K_BEQ,  -1,  1, -1);
    run_instr(K_BEQ,  -1,  0, -1);
    run_instr(K_JAL,  -1, -1, -1);
    run_instr(K_BADOP, -1, -1, -1);
    run_instr(K_SW,    3, -1, -1);
    run_instr(K_LW,   -1, -1, -1);
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(NKIND - 1);
      run_instr(k, ($urandom_range(15) == 0) ? int'($urandom_range(n_cycles(k) - 1)) : -1,
                -1, -1);
    end
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
